// File: rtl/debug_wb_arbiter.sv
// debug_wb_arbiter
//   Two-master Wishbone arbiter: m0 is the CPU, m1 the debug (UART) master.
//   m1 is only considered while debug_mode=1 and normally wins a simultaneous
//   request, but after FAIRNESS_MAX back-to-back wins over a waiting CPU the
//   CPU is served. Grants are registered (one cycle of arbitration latency);
//   once granted, the slave bus mirrors the owning master combinationally.
//
//   Build option: define DEBUG_WB_ARB_TIMEOUT_EN to add a stall watchdog.
//   A strobe left unanswered for TIMEOUT_CYCLES cycles is terminated with an
//   error to the owner, a timeout_o pulse, and a return to IDLE. Without the
//   macro a stalled slave holds the grant indefinitely and timeout_o is 0.
//
// Ports
//   core_clk, core_rstn      clock, synchronous active-low reset
//   debug_mode               allows m1 to request the bus
//   m0_* / m1_*              CPU / debug master Wishbone ports
//   s_*                      shared slave Wishbone port
//   grant_o                  one-hot {m1,m0}, 00 when idle
//   timeout_o                one-cycle watchdog pulse
//
// state | meaning
// IDLE  | no owner, slave strobes low, arbitrating on current requests
// GNT0  | CPU owns the slave until m0_cyc_i falls (or watchdog fires)
// GNT1  | debug master owns the slave until m1_cyc_i falls (or watchdog)

module debug_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int FAIRNESS_MAX   = 4
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        debug_mode,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,

  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam int FW = $clog2(FAIRNESS_MAX + 1);

  state_t          state, state_nxt;
  logic [FW-1:0]   fair_cnt, fair_nxt;
  logic            req0, req1;
  logic            timeout;

  assign req0 = m0_cyc_i;
  assign req1 = m1_cyc_i & debug_mode;

  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      state    <= IDLE;
      fair_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fair_cnt <= fair_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fair_nxt  = fair_cnt;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          // Debug wins ties until it has starved the CPU FAIRNESS_MAX times.
          if (fair_cnt == FW'(FAIRNESS_MAX)) state_nxt = GNT0;
          else                               state_nxt = GNT1;
        end else if (req0) begin
          state_nxt = GNT0;
        end else if (req1) begin
          state_nxt = GNT1;
        end

        if (state_nxt == GNT0) begin
          fair_nxt = '0;
        end else if (state_nxt == GNT1 && req0 && fair_cnt != FW'(FAIRNESS_MAX)) begin
          fair_nxt = fair_cnt + FW'(1);
        end
      end
      GNT0: if (!m0_cyc_i || timeout) state_nxt = IDLE;
      // debug_mode is deliberately ignored here so a started debug cycle completes.
      GNT1: if (!m1_cyc_i || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | timeout;
        m0_dat_o = s_dat_i;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | timeout;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

  assign grant_o   = state;
  assign timeout_o = timeout;

`ifdef DEBUG_WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          stalled;

  // to_cnt holds the number of earlier consecutive stalled cycles, so the
  // watchdog fires combinationally during the TIMEOUT_CYCLES-th one. The
  // state then leaves GNTx, so any later ack never reaches the master.
  assign stalled = (state != IDLE) && s_stb_o && !s_ack_i && !s_err_i;
  assign timeout = stalled && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge core_clk) begin
    if (!core_rstn)              to_cnt <= '0;
    else if (stalled && !timeout) to_cnt <= to_cnt + TW'(1);
    else                         to_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_debug_wb_arbiter.sv
module tb_debug_wb_arbiter;

  localparam int TO_CYC = 16;
  localparam int FMAX   = 4;

  logic        core_clk = 1'b0;
  logic        core_rstn;
  logic        debug_mode;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i, s_err_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: who owns the bus (0 none, 1 CPU, 2 debug), how many
  // times in a row debug has beaten a waiting CPU, and the current stall run.
  int m_own   = 0;
  int m_fair  = 0;
  int m_stall = 0;

  always #5 core_clk = ~core_clk;

  debug_wb_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .FAIRNESS_MAX(FMAX)) dut (
    .core_clk(core_clk), .core_rstn(core_rstn), .debug_mode(debug_mode),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check every output against the model for the current inputs, then take
  // one clock edge and advance the model. Returns 1 time unit after the edge.
  task automatic step();
    logic        e_cyc, e_stb, e_we, e_to, stalled, own_cyc;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_dat;
    logic        r0, r1;
    #3;
    e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 0; e_adr = 0; e_dat = 0; own_cyc = 0;
    if (m_own == 1) begin
      e_cyc = m0_cyc_i; e_stb = m0_stb_i; e_we = m0_we_i;
      e_sel = m0_sel_i; e_adr = m0_adr_i; e_dat = m0_dat_i; own_cyc = m0_cyc_i;
    end else if (m_own == 2) begin
      e_cyc = m1_cyc_i; e_stb = m1_stb_i; e_we = m1_we_i;
      e_sel = m1_sel_i; e_adr = m1_adr_i; e_dat = m1_dat_i; own_cyc = m1_cyc_i;
    end
    stalled = (m_own != 0) && e_stb && !s_ack_i && !s_err_i;
`ifdef DEBUG_WB_ARB_TIMEOUT_EN
    e_to = stalled && (m_stall == TO_CYC - 1);
`else
    e_to = 1'b0;
`endif
    chk("slave_side",
        {grant_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, timeout_o},
        {(m_own == 2) ? 2'b10 : (m_own == 1) ? 2'b01 : 2'b00,
         e_cyc, e_stb, e_we, e_sel, e_adr, e_dat, e_to});
    chk("master_side",
        {m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o},
        {(m_own == 1) && s_ack_i, (m_own == 1) && (s_err_i || e_to),
         (m_own == 1) ? s_dat_i : 32'h0,
         (m_own == 2) && s_ack_i, (m_own == 2) && (s_err_i || e_to),
         (m_own == 2) ? s_dat_i : 32'h0});
    @(posedge core_clk);
    if (!core_rstn) begin
      m_own = 0; m_fair = 0; m_stall = 0;
    end else if (m_own == 0) begin
      r0 = m0_cyc_i;
      r1 = m1_cyc_i && debug_mode;
      m_stall = 0;
      if (r0 && r1) m_own = (m_fair == FMAX) ? 1 : 2;
      else if (r0)  m_own = 1;
      else if (r1)  m_own = 2;
      if (m_own == 1) m_fair = 0;
      else if (m_own == 2 && r0 && m_fair < FMAX) m_fair = m_fair + 1;
    end else begin
      m_stall = (stalled && !e_to) ? m_stall + 1 : 0;
      if (e_to || !own_cyc) m_own = 0;
    end
    #1;
  endtask

  initial begin
    core_rstn = 0; debug_mode = 0;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
    s_dat_i = 32'hDEAD_BEEF; s_ack_i = 1; s_err_i = 1;

    // Reset with a noisy slave: nothing may leak through.
    repeat (2) @(posedge core_clk);
    #1;
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_slave", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}, 0);
    chk("rst_master", {m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o}, 0);
    chk("rst_timeout", timeout_o, 1'b0);
    s_ack_i = 0; s_err_i = 0;
    core_rstn = 1;
    step();

    // CPU-only read, slave acks after two wait cycles.
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_sel_i = 4'hF; m0_adr_i = 32'h2600_0000;
    step();
    chk("cpu_grant", grant_o, 2'b01);
    chk("cpu_adr", s_adr_o, 32'h2600_0000);
    step(); step();
    s_ack_i = 1; s_dat_i = 32'h0000_A000;
    #3;
    chk("cpu_ack", m0_ack_o, 1'b1);
    chk("cpu_dat", m0_dat_o, 32'h0000_A000);
    chk("cpu_m1_ack", m1_ack_o, 1'b0);
    step();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    step(); step();
    chk("cpu_release", grant_o, 2'b00);

    // Both masters requesting: four debug grants, then the CPU.
    debug_mode = 1;
    m0_cyc_i = 1; m0_stb_i = 1;
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'h3; m1_adr_i = 32'h100; m1_dat_i = 32'h55;
    for (int g = 0; g < 5; g++) begin
      step();
      chk($sformatf("fair_grant%0d", g), grant_o, (g < 4) ? 2'b10 : 2'b01);
      s_ack_i = 1;
      step();
      s_ack_i = 0;
      if (g < 4) begin
        m1_cyc_i = 0; m1_stb_i = 0;
        step();
        m1_cyc_i = 1; m1_stb_i = 1;
      end else begin
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();
      end
    end

    // Reset mid-GNT1 after debug has used up its fairness budget.
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    for (int g = 0; g < 4; g++) begin
      step();
      chk($sformatf("pre_rst_grant%0d", g), grant_o, 2'b10);
      if (g < 3) begin
        s_ack_i = 1; step(); s_ack_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; step();
        m1_cyc_i = 1; m1_stb_i = 1;
      end
    end
    core_rstn = 0; s_ack_i = 1;
    step();
    chk("midrst_grant", grant_o, 2'b00);
    chk("midrst_slave", {s_cyc_o, s_stb_o}, 2'b00);
    chk("midrst_m1", {m1_ack_o, m1_err_o, m1_dat_o}, 0);
    core_rstn = 1;
    step();
    chk("fair_cleared", grant_o, 2'b10);
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step(); step();

    // Debug write survives debug_mode dropping mid-grant.
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_dat_i = 32'h0000_AB00;
    step();
    chk("dbgdrop_grant", grant_o, 2'b10);
    debug_mode = 0;
    step();
    s_ack_i = 1;
    #3;
    chk("dbgdrop_ack", m1_ack_o, 1'b1);
    chk("dbgdrop_dat", s_dat_o, 32'h0000_AB00);
    step();
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step();
    chk("dbgdrop_idle", grant_o, 2'b00);

    // debug_mode=0: m1 is never served.
    m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
    for (int i = 0; i < 1000; i++) begin
      m0_cyc_i = 1'($urandom_range(0, 1)); m0_stb_i = m0_cyc_i;
      s_err_i = ($urandom_range(0, 7) == 0);
      s_dat_i = $urandom;
      #3;
      chk("nodbg_m1", {m1_ack_o, m1_err_o}, 2'b00);
      step();
    end
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0; s_err_i = 0;
    step(); step();

    // Stalled slave.
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    for (int i = 1; i <= TO_CYC; i++) begin
      #3;
`ifdef DEBUG_WB_ARB_TIMEOUT_EN
      chk($sformatf("to_pulse%0d", i), {timeout_o, m0_err_o}, (i == TO_CYC) ? 2'b11 : 2'b00);
`else
      chk($sformatf("to_pulse%0d", i), {timeout_o, m0_err_o}, 2'b00);
`endif
      step();
    end
`ifdef DEBUG_WB_ARB_TIMEOUT_EN
    chk("to_release", {s_cyc_o, grant_o}, 3'b000);
    s_ack_i = 1;
    #3;
    chk("to_late_ack", m0_ack_o, 1'b0);
    s_ack_i = 0;
`else
    for (int i = 0; i < 24; i++) step();
    chk("to_hold", {s_cyc_o, grant_o, timeout_o}, 4'b1010);
`endif
    m0_cyc_i = 0; m0_stb_i = 0;
    step(); step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      core_rstn  = ($urandom_range(0, 99) != 0);
      debug_mode = ($urandom_range(0, 7) != 0);
      m0_cyc_i = ($urandom_range(0, 3) != 0); m0_stb_i = 1'($urandom_range(0, 1));
      m0_we_i = 1'($urandom_range(0, 1)); m0_sel_i = 4'($urandom);
      m0_adr_i = $urandom; m0_dat_i = $urandom;
      m1_cyc_i = ($urandom_range(0, 3) != 0); m1_stb_i = 1'($urandom_range(0, 1));
      m1_we_i = 1'($urandom_range(0, 1)); m1_sel_i = 4'($urandom);
      m1_adr_i = $urandom; m1_dat_i = $urandom;
      s_ack_i = ($urandom_range(0, 9) == 0); s_err_i = ($urandom_range(0, 19) == 0);
      s_dat_i = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_wb_arbiter.md
DEBUG_WB_ARBITER -- requirements
Module: debug_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-low, named core_clk and core_rstn.
REQ-002 Parameters SHALL be:
- TIMEOUT_CYCLES, default 255: stalled-strobe cycles before forced error.
- FAIRNESS_MAX, default 4: consecutive debug grants allowed while the CPU waits.
REQ-003 Ports SHALL be:
- core_clk  in  1  clock
- core_rstn  in  1  sync active-low reset
- debug_mode  in  1  enables debug master arbitration
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  CPU master control
- m0_sel_i  in  4  CPU byte select
- m0_adr_i, m0_dat_i  in  32 each  CPU address / write data
- m0_dat_o  out  32  CPU read data
- m0_ack_o, m0_err_o  out  1 each  CPU ack / error
- m1_*  same set as m0_*  debug (UART) master
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control
- s_sel_o  out  4  slave byte select
- s_adr_o, s_dat_o  out  32 each  slave address / write data
- s_dat_i  in  32  slave read data
- s_ack_i, s_err_i  in  1 each  slave ack / error
- grant_o  out  2  one-hot {m1,m0}
- timeout_o  out  1  one-cycle timeout pulse

Function
REQ-004 FSM states SHALL be IDLE, GNT0 and GNT1, with grant_o = 00, 01 and 10 respectively.
REQ-005 Requests SHALL be defined as: req0 = m0_cyc_i; req1 = m1_cyc_i AND debug_mode.
REQ-006 In IDLE, arbitration SHALL be:
- req0 only -> GNT0.
- req1 only -> GNT1.
- Both requesting -> GNT1, unless the fairness count equals FAIRNESS_MAX, in which case GNT0.
REQ-007 The fairness count SHALL:
- increment on each IDLE->GNT1 taken while req0 is high;
- clear on entry to GNT0;
- saturate at FAIRNESS_MAX.
REQ-008 Grant SHALL be registered: the slave sees s_cyc_o in the cycle after the request is sampled in IDLE (1-cycle arbitration latency).
REQ-009 In a GNTx state, the slave outputs SHALL combinationally mirror master x, and s_cyc_o/s_stb_o SHALL be 0 in IDLE.
REQ-010 s_ack_i, s_err_i and s_dat_i SHALL be routed only to the granted master; the non-granted master's ack/err SHALL be 0 and its dat_o SHALL be 0.
REQ-011 GNTx SHALL hold while mx_cyc_i=1, and return to IDLE in the cycle after mx_cyc_i falls; there is no direct GNT0<->GNT1 transition.
REQ-012 debug_mode falling during GNT1 SHALL NOT abort the cycle: the grant holds until m1_cyc_i falls.
REQ-013 While debug_mode=0, m1 SHALL never receive ack or err.
REQ-014 Multi-beat transfers (stb toggling under continuous cyc) SHALL stay on one grant, with no re-arbitration.

Reset
REQ-015 While core_rstn=0 at a core_clk edge, the block SHALL force:
- state IDLE;
- fairness count 0 and timeout counter 0;
- grant_o=00, timeout_o=0;
- all s_* outputs 0 and all m*_ack/err/dat outputs 0.
REQ-016 Reset asserted mid-transaction SHALL drop s_cyc_o on the next edge, with no ack forwarded afterward.

Configuration
REQ-017 Macro DEBUG_WB_ARB_TIMEOUT_EN SHALL select the timeout behaviour:
- Defined: a counter SHALL count GNTx cycles with s_stb_o=1 and s_ack_i=s_err_i=0, clearing on ack, err or stb low.
- Defined: on reaching TIMEOUT_CYCLES, the block SHALL assert mx_err_o for one cycle, pulse timeout_o, and go to IDLE.
- Defined: a late s_ack_i after timeout SHALL be ignored.
- Not defined: there SHALL be no counter, timeout_o SHALL be tied 0, and a stalled slave SHALL hold the grant indefinitely.

Verification
REQ-018 CPU-only access: m0 read at 0x2600_0000 with slave ack after 2 cycles, dat 0xA000 -> m0_ack_o=1, m0_dat_o=0x0000A000, grant_o=01, m1_ack_o=0.
REQ-019 Simultaneous requests with debug_mode=1 -> grant_o=10 first; after the m1 cycle ends, the next grant is still 10 if m1 re-requests, up to 4 grants, then 01.
REQ-020 debug_mode=0 with m1 and m0 both requesting -> only m0 is served; m1_ack_o stays 0 for 1000 cycles.
REQ-021 debug_mode dropped mid-GNT1 -> the m1 write of 0x0000AB00 completes with ack, then IDLE.
REQ-022 With DEBUG_WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never acks -> m0_err_o and timeout_o pulse on the 16th stalled cycle, s_cyc_o=0 the next cycle; without the macro, the grant holds.
REQ-023 core_rstn=0 for 1 cycle during an active GNT1 -> grant_o=00 and all outputs 0 at the next edge, with the fairness count cleared.
